// File: rtl/uart_rx_fifo.sv
// Buffers UART receive bytes in a circular FIFO and presents them on a first-word-fall-through read port.
// A byte is readable one cycle after the strobe edge. Bytes arriving while full (with no pop) are dropped and set Overrun.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic                  RX_Receive,
  input  logic [7:0]            RX_Data,
  input  logic                  Read_Ready,
  output logic                  Read_Valid,
  output logic [7:0]            Read_Data,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Overrun,
  input  logic                  Overrun_Clear
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  Strobe_Prev;

  logic write_req;
  logic pop;
  logic wr_en;
  logic overrun_set;

  assign Full       = (Level == LEVEL_MAX);
  assign Empty      = (Level == '0);
  assign Read_Valid = ~Empty;
  assign Read_Data  = Empty ? 8'h00 : mem[rd_ptr];

  // A full FIFO still accepts a byte when the same cycle pops one out.
  assign write_req   = RX_Receive & ~Strobe_Prev;
  assign pop         = Read_Valid & Read_Ready;
  assign wr_en       = write_req & (~Full | pop);
  assign overrun_set = write_req & Full & ~pop;

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= RX_Data;
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      Strobe_Prev <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Level       <= '0;
      Overrun     <= 1'b0;
    end else begin
      Strobe_Prev <= RX_Receive;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   Level <= Level + LEVEL_ONE;
        2'b01:   Level <= Level - LEVEL_ONE;
        default: Level <= Level;
      endcase
      if (overrun_set) begin
        Overrun <= 1'b1;
      end else if (Overrun_Clear) begin
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte on the rising edge of the receiver's one-cycle "byte received" strobe and stores it in a circular FIFO. The buffered bytes are presented to the consumer through a first-word-fall-through valid/ready read port. Full, empty, fill-level and a sticky overrun flag are exported so host logic can drain in bursts without losing characters.

## Interface
- DEPTH_LOG2, 4: log2 of FIFO depth; depth = 2^DEPTH_LOG2 bytes (16 by default). Legal values are 1 to 8.
- Clock  input  1  system clock, same domain as the UART receiver.
- Reset_N  input  1  asynchronous, active-low reset.
- RX_Receive  input  1  byte-received strobe from the UART receiver. Only its rising edge is acted on.
- RX_Data  input  8  received byte; valid in the cycle RX_Receive is high.
- Read_Ready  input  1  consumer accepts the byte on Read_Data this cycle.
- Read_Valid  output  1  FIFO non-empty; Read_Data holds the oldest byte.
- Read_Data  output  8  oldest stored byte; forced to 8'h00 while Read_Valid is 0.
- Level  output  DEPTH_LOG2+1  number of stored bytes, 0 to 2^DEPTH_LOG2.
- Full  output  1  Level == 2^DEPTH_LOG2.
- Empty  output  1  Level == 0 (equal to ~Read_Valid).
- Overrun  output  1  sticky; set when a byte arrives while the FIFO is full.
- Overrun_Clear  input  1  synchronous clear of Overrun.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 register array, plus DEPTH_LOG2-bit write and read pointers and a DEPTH_LOG2+1-bit Level counter.
- Pointers wrap modulo depth with natural binary overflow. Full and empty are distinguished by Level only, never by pointer comparison.
- Edge detect: the register Strobe_Prev samples RX_Receive every cycle. Write request is RX_Receive & ~Strobe_Prev.
  - A strobe held high for several cycles yields exactly one write.
- Write request and not Full: RX_Data is stored at the write pointer, the write pointer increments, and Level increments.
- Write request and Full, with no pop this cycle: the byte is dropped, Overrun is set, and pointers and Level are unchanged.
- Pop (Read_Valid & Read_Ready): the read pointer increments and Level decrements.
  - Read_Ready while Empty is ignored; there is no underflow and no state change.
- Simultaneous write request and pop:
  - Not empty and not full: both occur and Level is unchanged.
  - Full: the pop frees a slot, the write is accepted, Overrun is not set, and Level stays at the maximum.
  - Empty: no pop occurs, so only the write happens.
- Overrun: set wins over Overrun_Clear when both occur in the same cycle. Otherwise Overrun_Clear returns it to 0. Otherwise Overrun holds its value.
- No state machine beyond the FIFO control. All control is registered on the rising edge of Clock.

## Timing
- Reset (Reset_N low, asynchronous) clears the following: pointers, Level, Strobe_Prev, Overrun.
  - Outputs during and after reset: Read_Valid=0, Read_Data=8'h00, Level=0, Full=0, Empty=1, Overrun=0.
  - Array contents are not reset.
- Reset asserted mid-transfer discards all stored bytes immediately. Recovery is synchronous on the first Clock edge after deassertion.
- Write latency: RX_Receive rises and is sampled at edge N. Read_Valid=1 and Read_Data show the byte from just after edge N, i.e. in cycle N+1.
- Read port is first-word-fall-through:
  - Read_Data is combinational from the array at the read pointer, masked when empty.
  - After a pop at edge M, the next byte, or masking to 00, appears in cycle M+1.
- Level, Full and Empty are all updated at the same edge as the write or pop that changes them.
- Throughput: one write and one pop per cycle.

## Test plan
- Single byte: reset, then pulse RX_Receive for 1 cycle with RX_Data=8'hA5.
  - Next cycle: Read_Valid=1, Read_Data=A5, Level=1.
  - Assert Read_Ready for 1 cycle: afterwards Empty=1 and Read_Data=00.
- Held strobe: hold RX_Receive high for 5 cycles with 8'h3C, then low. Required: Level=1, and only one 3C is read out.
- Fill and overrun (DEPTH_LOG2=4):
  - Write bytes 00 to 0F: Full=1, Level=16, Overrun=0.
  - 17th byte 8'hFF: dropped, Overrun=1, Level=16.
  - Drain: reads return 00 to 0F in order, then Empty=1.
- Full plus simultaneous pop: with the FIFO full of 00 to 0F, strobe 8'h77 in the same cycle as a pop.
  - Required: Overrun=0, Level=16.
  - Drain order is 01 to 0F, then 77; pointers have wrapped correctly.
- Overrun precedence: with the FIFO full, assert Overrun_Clear in the same cycle as an incoming byte. Overrun=1. A later Overrun_Clear alone gives Overrun=0.
- Reset mid-operation: with 5 bytes stored, pulse Reset_N low between edges.
  - Outputs go immediately to Level=0, Empty=1, Read_Data=00, Overrun=0.
  - A new byte 8'h5A after release is the first one read.
